// File: rtl/add_rs_dispatch.sv
// Reservation station for the add/sub unit: holds pending ops, snoops the CDB for
// late operands and dispatches the oldest ready entry, one op in flight at a time.
module add_rs_dispatch #(
    parameter int NUM_ENTRIES = 3,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 3
) (
    input  logic                               clk1,
    input  logic                               rst_n,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [6:0]                         issue_fun7,
    input  logic [TAG_W-1:0]                   issue_des,
    input  logic                               issue_rdy1,
    input  logic [DATA_W-1:0]                  issue_data1,
    input  logic [TAG_W-1:0]                   issue_tag1,
    input  logic                               issue_rdy2,
    input  logic [DATA_W-1:0]                  issue_data2,
    input  logic [TAG_W-1:0]                   issue_tag2,
    input  logic                               cdb_valid,
    input  logic [TAG_W-1:0]                   cdb_tag,
    input  logic [DATA_W-1:0]                  cdb_data,
    output logic                               fla,
    output logic [DATA_W-1:0]                  data1,
    output logic [DATA_W-1:0]                  data2,
    output logic [TAG_W-1:0]                   des,
    output logic [6:0]                         fun7,
    input  logic                               fu_done,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy,
    output logic                               err_fun7
);

    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [6:0] FUN_ADD = 7'b0000000;
    localparam logic [6:0] FUN_SUB = 7'b0100000;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic legal_fun7(input logic [6:0] f);
        return (f == FUN_ADD) || (f == FUN_SUB);
    endfunction

    state_t state_q, state_d;

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [6:0]             e_fun7_q [NUM_ENTRIES];
    logic [TAG_W-1:0]       e_des_q  [NUM_ENTRIES];
    logic                   rdy1_q   [NUM_ENTRIES];
    logic [DATA_W-1:0]      val1_q   [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag1_q   [NUM_ENTRIES];
    logic                   rdy2_q   [NUM_ENTRIES];
    logic [DATA_W-1:0]      val2_q   [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag2_q   [NUM_ENTRIES];
    // Age is the entry's position in program order among valid entries, 0 = oldest.
    logic [IDX_W-1:0]       age_q    [NUM_ENTRIES];

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_age;
    logic [OCC_W-1:0] occ_c;
    logic             issue_fire;
    logic             alloc;
    logic             disp_en;
    logic [IDX_W-1:0] alloc_age;
    logic             in_rdy1, in_rdy2;
    logic [DATA_W-1:0] in_val1, in_val2;

    assign issue_ready = ~&valid_q;
    assign occupancy   = occ_c;
    assign issue_fire  = issue_valid && issue_ready;
    assign alloc       = issue_fire && legal_fun7(issue_fun7);

    // Issue-cycle bypass from the CDB for operands not yet ready.
    assign in_rdy1 = issue_rdy1 || (cdb_valid && (cdb_tag == issue_tag1));
    assign in_rdy2 = issue_rdy2 || (cdb_valid && (cdb_tag == issue_tag2));
    assign in_val1 = issue_rdy1 ? issue_data1 : cdb_data;
    assign in_val2 = issue_rdy2 ? issue_data2 : cdb_data;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i] &&
                (!sel_found || (age_q[i] < sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
        end
    end

    always_comb begin
        occ_c = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occ_c = occ_c + OCC_W'(valid_q[i]);
        end
    end

    // A new entry lands behind every survivor, so its age is the surviving count.
    assign alloc_age = IDX_W'(occ_c - OCC_W'(disp_en));

    // FSM: state register
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found) state_d = BUSY;
            BUSY:    if (fu_done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        disp_en = 1'b0;
        if (state_q == IDLE) begin
            disp_en = sel_found;
        end
    end

    // Entry storage: free on dispatch, snoop CDB, allocate on issue
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (disp_en && (sel_idx == IDX_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end else if (valid_q[i]) begin
                    if (!rdy1_q[i] && cdb_valid && (cdb_tag == tag1_q[i])) begin
                        rdy1_q[i] <= 1'b1;
                        val1_q[i] <= cdb_data;
                    end
                    if (!rdy2_q[i] && cdb_valid && (cdb_tag == tag2_q[i])) begin
                        rdy2_q[i] <= 1'b1;
                        val2_q[i] <= cdb_data;
                    end
                    if (disp_en && (age_q[i] > sel_age)) begin
                        age_q[i] <= age_q[i] - IDX_W'(1);
                    end
                end
                if (alloc && (free_idx == IDX_W'(i))) begin
                    valid_q[i]  <= 1'b1;
                    e_fun7_q[i] <= issue_fun7;
                    e_des_q[i]  <= issue_des;
                    rdy1_q[i]   <= in_rdy1;
                    val1_q[i]   <= in_val1;
                    tag1_q[i]   <= issue_tag1;
                    rdy2_q[i]   <= in_rdy2;
                    val2_q[i]   <= in_val2;
                    tag2_q[i]   <= issue_tag2;
                    age_q[i]    <= alloc_age;
                end
            end
        end
    end

    // Dispatch registers toward the adder
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            fla      <= 1'b0;
            data1    <= '0;
            data2    <= '0;
            des      <= '0;
            fun7     <= '0;
            err_fun7 <= 1'b0;
        end else begin
            fla      <= disp_en;
            err_fun7 <= issue_fire && !legal_fun7(issue_fun7);
            if (disp_en) begin
                data1 <= val1_q[sel_idx];
                data2 <= val2_q[sel_idx];
                des   <= e_des_q[sel_idx];
                fun7  <= e_fun7_q[sel_idx];
            end
        end
    end

endmodule

// File: tb/tb_add_rs_dispatch.sv
// Directed bench for add_rs_dispatch: issue, CDB wakeup, age order, bypass,
// illegal opcode and mid-flight reset.
module tb_add_rs_dispatch;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [6:0]  issue_fun7;
    logic [2:0]  issue_des;
    logic        issue_rdy1;
    logic [31:0] issue_data1;
    logic [2:0]  issue_tag1;
    logic        issue_rdy2;
    logic [31:0] issue_data2;
    logic [2:0]  issue_tag2;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fla;
    logic [31:0] data1, data2;
    logic [2:0]  des;
    logic [6:0]  fun7;
    logic        fu_done;
    logic [1:0]  occupancy;
    logic        err_fun7;

    int tests = 0;
    int fails = 0;

    always #5 clk1 = ~clk1;

    add_rs_dispatch #(.NUM_ENTRIES(3), .DATA_W(32), .TAG_W(3)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_fun7(issue_fun7), .issue_des(issue_des),
        .issue_rdy1(issue_rdy1), .issue_data1(issue_data1), .issue_tag1(issue_tag1),
        .issue_rdy2(issue_rdy2), .issue_data2(issue_data2), .issue_tag2(issue_tag2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fla(fla), .data1(data1), .data2(data2), .des(des), .fun7(fun7),
        .fu_done(fu_done), .occupancy(occupancy), .err_fun7(err_fun7)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [6:0] f, input logic [2:0] d,
                         input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                         input logic r2, input logic [31:0] v2, input logic [2:0] t2);
        issue_valid = 1'b1;
        issue_fun7  = f;
        issue_des   = d;
        issue_rdy1  = r1;
        issue_data1 = v1;
        issue_tag1  = t1;
        issue_rdy2  = r2;
        issue_data2 = v2;
        issue_tag2  = t2;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = v;
    endtask

    task automatic quiet();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        fu_done     = 1'b0;
    endtask

    task automatic done_pulse();
        fu_done = 1'b1;
        tick();
        fu_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        issue(7'h00, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0);
        issue_valid = 1'b0;
        cdb_tag = 3'd0;
        cdb_data = 32'd0;
        tick();
        tick();
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_fla", 32'(fla), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_data1", data1, 32'd0);
        chk("rst_err", 32'(err_fun7), 32'd0);
        rst_n = 1'b1;
        tick();

        // both operands ready at issue
        issue(7'h00, 3'd2, 1'b1, 32'd5, 3'd0, 1'b1, 32'd3, 3'd0);
        tick();
        quiet();
        chk("t1_occ1", 32'(occupancy), 32'd1);
        chk("t1_fla_early", 32'(fla), 32'd0);
        tick();
        chk("t1_fla", 32'(fla), 32'd1);
        chk("t1_data1", data1, 32'd5);
        chk("t1_data2", data2, 32'd3);
        chk("t1_des", 32'(des), 32'd2);
        chk("t1_fun7", 32'(fun7), 32'h00);
        chk("t1_occ0", 32'(occupancy), 32'd0);
        tick();
        chk("t1_fla_once", 32'(fla), 32'd0);
        chk("t1_hold", data1, 32'd5);
        done_pulse();

        // sub waiting on tag 4, woken three cycles later
        issue(7'h20, 3'd3, 1'b1, 32'd7, 3'd0, 1'b0, 32'd0, 3'd4);
        tick();
        quiet();
        cdb(3'd5, 32'hdead);
        tick();
        cdb_valid = 1'b0;
        chk("t2_wrongtag", 32'(fla), 32'd0);
        tick();
        chk("t2_wait", 32'(fla), 32'd0);
        cdb(3'd4, 32'h10);
        tick();
        cdb_valid = 1'b0;
        chk("t2_no_same_cycle", 32'(fla), 32'd0);
        tick();
        chk("t2_fla", 32'(fla), 32'd1);
        chk("t2_data1", data1, 32'd7);
        chk("t2_data2", data2, 32'h10);
        chk("t2_fun7", 32'(fun7), 32'h20);
        chk("t2_des", 32'(des), 32'd3);
        tick();
        chk("t2_fla_once", 32'(fla), 32'd0);
        done_pulse();

        // fill station: e0 waits tag6, e1 waits tag7, e2 waits tag6
        issue(7'h00, 3'd1, 1'b0, 32'd0, 3'd6, 1'b1, 32'd100, 3'd0);
        tick();
        issue(7'h00, 3'd5, 1'b0, 32'd0, 3'd7, 1'b1, 32'd50, 3'd0);
        tick();
        issue(7'h20, 3'd6, 1'b1, 32'd20, 3'd0, 1'b0, 32'd0, 3'd6);
        tick();
        chk("t3_full_ready", 32'(issue_ready), 32'd0);
        chk("t3_occ3", 32'(occupancy), 32'd3);
        issue(7'h00, 3'd7, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
        tick();
        quiet();
        chk("t3_ignored_occ", 32'(occupancy), 32'd3);
        tick();
        chk("t3_ignored_fla", 32'(fla), 32'd0);
        cdb(3'd6, 32'h40);
        tick();
        cdb_valid = 1'b0;
        chk("t3_wake_fla", 32'(fla), 32'd0);
        tick();
        chk("t3_e0_fla", 32'(fla), 32'd1);
        chk("t3_e0_des", 32'(des), 32'd1);
        chk("t3_e0_data1", data1, 32'h40);
        chk("t3_e0_data2", data2, 32'd100);
        chk("t3_occ2", 32'(occupancy), 32'd2);
        tick();
        chk("t3_busy_fla", 32'(fla), 32'd0);
        done_pulse();
        chk("t3_gap_fla", 32'(fla), 32'd0);
        tick();
        chk("t3_e2_fla", 32'(fla), 32'd1);
        chk("t3_e2_des", 32'(des), 32'd6);
        chk("t3_e2_data1", data1, 32'd20);
        chk("t3_e2_data2", data2, 32'h40);

        // bypass on issue while e1 wakes on the same broadcast; e1 is older
        issue(7'h00, 3'd0, 1'b0, 32'd0, 3'd7, 1'b1, 32'd1, 3'd0);
        cdb(3'd7, 32'h77);
        tick();
        quiet();
        chk("t4_occ2", 32'(occupancy), 32'd2);
        done_pulse();
        tick();
        chk("t4_old_fla", 32'(fla), 32'd1);
        chk("t4_old_des", 32'(des), 32'd5);
        chk("t4_old_data1", data1, 32'h77);
        chk("t4_old_data2", data2, 32'd50);
        tick();
        done_pulse();
        tick();
        chk("t4_byp_fla", 32'(fla), 32'd1);
        chk("t4_byp_des", 32'(des), 32'd0);
        chk("t4_byp_data1", data1, 32'h77);
        chk("t4_byp_data2", data2, 32'd1);
        chk("t4_occ0", 32'(occupancy), 32'd0);
        done_pulse();

        // illegal opcode
        issue(7'h01, 3'd3, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2, 3'd0);
        tick();
        quiet();
        chk("t5_err", 32'(err_fun7), 32'd1);
        chk("t5_occ", 32'(occupancy), 32'd0);
        tick();
        chk("t5_err_once", 32'(err_fun7), 32'd0);
        chk("t5_fla", 32'(fla), 32'd0);
        tick();
        chk("t5_fla2", 32'(fla), 32'd0);

        // reset while busy with two entries waiting
        issue(7'h00, 3'd2, 1'b0, 32'd0, 3'd3, 1'b1, 32'd4, 3'd0);
        tick();
        issue(7'h00, 3'd1, 1'b1, 32'd11, 3'd0, 1'b1, 32'd12, 3'd0);
        tick();
        issue(7'h00, 3'd4, 1'b0, 32'd0, 3'd5, 1'b1, 32'd6, 3'd0);
        tick();
        quiet();
        chk("t6_busy_fla", 32'(fla), 32'd1);
        chk("t6_busy_occ", 32'(occupancy), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_occ", 32'(occupancy), 32'd0);
        chk("t6_rst_fla", 32'(fla), 32'd0);
        chk("t6_rst_ready", 32'(issue_ready), 32'd1);
        chk("t6_rst_des", 32'(des), 32'd0);
        done_pulse();
        tick();
        chk("t6_post_fla", 32'(fla), 32'd0);
        chk("t6_post_occ", 32'(occupancy), 32'd0);
        issue(7'h20, 3'd6, 1'b1, 32'd9, 3'd0, 1'b1, 32'd8, 3'd0);
        tick();
        quiet();
        tick();
        chk("t6_after_fla", 32'(fla), 32'd1);
        chk("t6_after_des", 32'(des), 32'd6);
        chk("t6_after_data1", data1, 32'd9);
        done_pulse();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
